uart_rx_os: RTL and testbench

Parametrised, oversampling UART receiver; successor to the team's fixed 8-bit, one-sample-per-bit receiver. Adds the following:
- configurable data width, parity and stop bits
- an input synchroniser and start-bit validation
- 3-sample majority voting per bit
- a ready/valid output register
- per-frame parity, framing and overrun error reporting

Sits between the rx pad and the UART host-side FIFO/CSR block.

---
 rtl/uart_rx_os.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_os.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os
// Brief    : Oversampling UART receiver with 3-sample majority vote, optional
//            parity, 1/2 stop bits, ready/valid holding register and errors.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  uart_clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    localparam int c_cnt_w = $clog2(OVERSAMPLE);
    localparam int c_idx_w = $clog2(DATA_WIDTH);

    localparam logic [c_cnt_w-1:0] c_mid      = c_cnt_w'(OVERSAMPLE / 2);
    localparam logic [c_cnt_w-1:0] c_mid_m1   = c_cnt_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_mid_m2   = c_cnt_w'(OVERSAMPLE / 2 - 2);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(OVERSAMPLE - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_last_bit = c_idx_w'(DATA_WIDTH - 1);
    localparam logic               c_last_stop = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_idx_w-1:0]    r_bit_idx;
    logic                  r_stop_idx;
    logic                  r_v0;
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_err;
    logic                  r_frm_err;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_perr_q;
    logic                  r_ferr_q;
    logic                  r_ovr;

    logic w_vote;
    logic w_at_mid;
    logic w_accept;
    logic w_par_exp;
    logic w_frm_final;

    // Third vote sample is the live synchronised line in the MID cycle itself
    assign w_vote      = (r_v0 & r_v1) | (r_v0 & r_rx_s) | (r_v1 & r_rx_s);
    assign w_at_mid    = (r_cnt == c_mid);
    assign w_accept    = r_valid & rx_ready;
    assign w_par_exp   = (PARITY_MODE == 1) ? ~(^r_shift) : (^r_shift);
    assign w_frm_final = r_frm_err | ~w_vote;

    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_v0       <= 1'b1;
            r_v1       <= 1'b1;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr_q   <= 1'b0;
            r_ferr_q   <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
            r_ovr     <= 1'b0;

            if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (r_cnt == c_mid_m2) begin
                r_v0 <= r_rx_s;
            end
            if (r_cnt == c_mid_m1) begin
                r_v1 <= r_rx_s;
            end
            if (r_state != S_IDLE && r_state != S_WAIT_IDLE) begin
                r_cnt <= (r_cnt == c_last_cnt) ? '0 : r_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    // Detection cycle counts as sample 0 of the start bit
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= c_one;
                    end
                end
                S_START: begin
                    if (w_at_mid) begin
                        if (w_vote) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                            r_par_err <= 1'b0;
                            r_frm_err <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_at_mid) begin
                        r_shift[r_bit_idx] <= w_vote;
                        if (r_bit_idx == c_last_bit) begin
                            r_stop_idx <= 1'b0;
                            r_state    <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_at_mid) begin
                        r_par_err  <= (w_vote != w_par_exp);
                        r_stop_idx <= 1'b0;
                        r_state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_at_mid) begin
                        r_frm_err <= w_frm_final;
                        if (r_stop_idx == c_last_stop) begin
                            // Commit beats the accept-clear above when both happen
                            if (!r_valid || w_accept) begin
                                r_data   <= r_shift;
                                r_perr_q <= r_par_err;
                                r_ferr_q <= w_frm_final;
                                r_valid  <= 1'b1;
                            end else begin
                                r_ovr <= 1'b1;
                            end
                            r_cnt   <= '0;
                            r_state <= w_vote ? S_IDLE : S_WAIT_IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign parity_err  = r_perr_q;
    assign frame_err   = r_ferr_q;
    assign overrun_err = r_ovr;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_os
// Brief    : Directed scoreboard bench for uart_rx_os (8N1 and 8E1 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_p, rdy_a, rdy_p;
    logic [7:0] data_a, data_p;
    logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
    logic       valid_p, perr_p, ferr_p, ovr_p, busy_p;

    int total = 0;
    int bad   = 0;
    int ovr_cnt_a = 0;

    // Scoreboard entries are {frame_err, parity_err, data}
    logic [9:0] exp_a[$];
    logic [9:0] exp_p[$];

    always #5 clk = ~clk;

    uart_rx_os dut_a (
        .uart_clk(clk), .rst_n(rst_n), .rx_in(rx_a), .rx_data(data_a),
        .rx_valid(valid_a), .rx_ready(rdy_a), .parity_err(perr_a),
        .frame_err(ferr_a), .overrun_err(ovr_a), .busy(busy_a)
    );

    uart_rx_os #(.PARITY_MODE(2)) dut_p (
        .uart_clk(clk), .rst_n(rst_n), .rx_in(rx_p), .rx_data(data_p),
        .rx_valid(valid_p), .rx_ready(rdy_p), .parity_err(perr_p),
        .frame_err(ferr_p), .overrun_err(ovr_p), .busy(busy_p)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input bit which, input logic [9:0] got);
        int         n;
        logic [9:0] e;
        n = which ? exp_p.size() : exp_a.size();
        total++;
        assert (n != 0) else begin
            bad++;
            $error("FAIL sb_%0d unexpected word got=%0h exp=none", which, got);
        end
        if (n != 0) begin
            if (which) e = exp_p.pop_front();
            else       e = exp_a.pop_front();
            total++;
            assert (got === e) else begin
                bad++;
                $error("FAIL sb_%0d word got=%0h exp=%0h", which, got, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ovr_a) ovr_cnt_a++;
            if (valid_a && rdy_a) sb_pop(1'b0, {ferr_a, perr_a, data_a});
            if (valid_p && rdy_p) sb_pop(1'b1, {ferr_p, perr_p, data_p});
        end
    end

    task automatic drive(input bit tgt, input logic v, input int ncyc);
        if (tgt) rx_p = v;
        else     rx_a = v;
        repeat (ncyc) @(posedge clk);
        #1;
    endtask

    // par < 0: no parity bit; glitch >= 0: one-cycle inversion at sample MID-1 of that data bit
    task automatic send(input bit tgt, input logic [7:0] d, input int par,
                        input logic stop_v, input int glitch);
        drive(tgt, 1'b0, OS);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch) begin
                drive(tgt, d[i], 7);
                drive(tgt, ~d[i], 1);
                drive(tgt, d[i], 8);
            end else begin
                drive(tgt, d[i], OS);
            end
        end
        if (par >= 0) drive(tgt, par[0], OS);
        drive(tgt, stop_v, OS);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int         lat, bcnt, vcnt, ovr_base;
        logic       pb;
        logic [7:0] pv;

        rst_n = 1'b0; rx_a = 1'b1; rx_p = 1'b1; rdy_a = 1'b1; rdy_p = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", data_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_perr", perr_a, 0);
        check("rst_ferr", ferr_a, 0);
        check("rst_ovr", ovr_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_valid_p", valid_p, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, OS);

        // 0xA5 8N1: rx_valid first seen 155 cycles after the rx_in falling edge
        exp_a.push_back({2'b00, 8'hA5});
        fork
            send(1'b0, 8'hA5, -1, 1'b1, -1);
            begin
                lat = 0;
                pb  = 1'b0;
                @(negedge clk);
                while (!valid_a && lat < 400) begin
                    pb = busy_a;
                    @(negedge clk);
                    lat++;
                end
                check("latency", lat, 155);
                check("busy_at_valid", busy_a, 0);
                check("busy_before_valid", pb, 1);
                @(negedge clk);
                check("valid_one_cycle", valid_a, 0);
            end
        join
        drive(1'b0, 1'b1, 2 * OS);

        // Even parity: forced wrong bit, then correct bit
        pv = 8'h3C;
        exp_p.push_back({2'b01, pv});
        send(1'b1, pv, 1, 1'b1, -1);
        drive(1'b1, 1'b1, 2 * OS);
        exp_p.push_back({2'b00, pv});
        send(1'b1, pv, int'(^pv), 1'b1, -1);
        drive(1'b1, 1'b1, 2 * OS);
        check("sb_p_drained", exp_p.size(), 0);

        // Framing error followed by a 40-bit break
        exp_a.push_back({2'b10, 8'h5A});
        send(1'b0, 8'h5A, -1, 1'b0, -1);
        drive(1'b0, 1'b0, 20 * OS);
        check("break_busy_mid", busy_a, 1);
        drive(1'b0, 1'b0, 20 * OS);
        check("break_busy_end", busy_a, 1);
        check("break_no_valid", valid_a, 0);
        drive(1'b0, 1'b1, 2 * OS);
        check("break_idle", busy_a, 0);
        exp_a.push_back({2'b00, 8'h11});
        send(1'b0, 8'h11, -1, 1'b1, -1);
        drive(1'b0, 1'b1, 2 * OS);
        check("sb_a_after_break", exp_a.size(), 0);

        // Short start glitch: rejected at the start-bit MID
        bcnt = 0;
        vcnt = 0;
        rx_a = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 4) rx_a = 1'b1;
            if (busy_a)  bcnt++;
            if (valid_a) vcnt++;
        end
        check("glitch_no_valid", vcnt, 0);
        check("glitch_busy_window", (bcnt >= 1 && bcnt <= 11), 1);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, OS);

        // One-cycle low glitch inside data bit 2 is voted out
        exp_a.push_back({2'b00, 8'h96});
        send(1'b0, 8'h96, -1, 1'b1, 2);
        drive(1'b0, 1'b1, 2 * OS);
        check("sb_a_after_glitch", exp_a.size(), 0);

        // Overrun: back-to-back frames with the holding register full
        ovr_base = ovr_cnt_a;
        rdy_a = 1'b0;
        exp_a.push_back({2'b00, 8'h01});
        send(1'b0, 8'h01, -1, 1'b1, -1);
        send(1'b0, 8'h02, -1, 1'b1, -1);
        check("overrun_once", ovr_cnt_a - ovr_base, 1);
        check("held_valid", valid_a, 1);
        check("held_data", data_a, 8'h01);

        // Accept exactly in the third frame's commit cycle
        exp_a.push_back({2'b00, 8'h03});
        fork
            send(1'b0, 8'h03, -1, 1'b1, -1);
            begin
                repeat (154) @(posedge clk);
                #1 rdy_a = 1'b1;
                @(posedge clk);
                #1 rdy_a = 1'b0;
                @(negedge clk);
                check("commit_accept_valid", valid_a, 1);
                check("commit_accept_data", data_a, 8'h03);
                check("commit_accept_no_ovr", ovr_cnt_a - ovr_base, 1);
            end
        join
        rdy_a = 1'b1;
        drive(1'b0, 1'b1, 2 * OS);
        check("sb_a_after_overrun", exp_a.size(), 0);

        // Reset pulse during data bit 4 of 0xFF
        fork
            send(1'b0, 8'hFF, -1, 1'b1, -1);
            begin
                repeat (87) @(posedge clk);
                #1 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                @(negedge clk);
                check("midrst_data", data_a, 0);
                check("midrst_valid", valid_a, 0);
                check("midrst_perr", perr_a, 0);
                check("midrst_ferr", ferr_a, 0);
                check("midrst_ovr", ovr_a, 0);
                check("midrst_busy", busy_a, 0);
            end
        join
        drive(1'b0, 1'b1, OS);
        exp_a.push_back({2'b00, 8'h81});
        send(1'b0, 8'h81, -1, 1'b1, -1);
        drive(1'b0, 1'b1, 2 * OS);

        check("final_sb_a_empty", exp_a.size(), 0);
        check("final_sb_p_empty", exp_p.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
